// File: rtl/linear_layer_sched.sv
// Row scheduler for the quantized linear layer: issues one dot-product per output row,
// requantizes the 32-bit accumulation and writes it to the output activation memory.
module linear_layer_sched #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int VEC_LEN    = 8,
    parameter int SHIFT_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   num_rows,
    input  logic [SHIFT_W-1:0]      out_shift,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   row_idx,
    output logic                    dp_start,
    output logic [ADDR_WIDTH-1:0]   dp_base_addr,
    input  logic [2*DATA_WIDTH-1:0] dp_result,
    input  logic                    dp_done,
    output logic                    out_wr_en,
    output logic [ADDR_WIDTH-1:0]   out_wr_addr,
    output logic [DATA_WIDTH-1:0]   out_wr_data,
    output logic [2:0]              dbg_state
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_DP = 3'd2,
        S_WRITE   = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   rows_q;
    logic [SHIFT_W-1:0]      shift_q;
    logic [ADDR_WIDTH-1:0]   row_idx_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic signed [RW-1:0]    res_q;
    logic signed [RW-1:0]    shifted;
    logic                    last_row;

    assign last_row = (row_idx_q == (rows_q - ADDR_WIDTH'(1)));

    // abort outranks every other transition; a WRITE cycle still strobes because
    // out_wr_en is decoded from the current state, not the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            shift_q   <= '0;
            row_idx_q <= '0;
            base_q    <= '0;
            res_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (num_rows != '0) begin
                            rows_q    <= num_rows;
                            shift_q   <= out_shift;
                            row_idx_q <= '0;
                            base_q    <= '0;
                            state_q   <= S_ISSUE;
                        end else begin
                            state_q   <= S_FINISH;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= abort ? S_IDLE : S_WAIT_DP;
                end
                S_WAIT_DP: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (dp_done) begin
                        res_q   <= dp_result;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (last_row) begin
                        state_q <= S_FINISH;
                    end else begin
                        row_idx_q <= row_idx_q + ADDR_WIDTH'(1);
                        base_q    <= base_q + ADDR_WIDTH'(VEC_LEN);
                        state_q   <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Arithmetic shift truncates toward -inf, then clamp to the activation range.
    assign shifted = res_q >>> shift_q;

    always_comb begin
        out_wr_data = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            out_wr_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            out_wr_data = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
    assign dp_start     = (state_q == S_ISSUE);
    assign out_wr_en    = (state_q == S_WRITE);
    assign row_idx      = row_idx_q;
    assign dp_base_addr = base_q;
    assign out_wr_addr  = row_idx_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_linear_layer_sched.sv
// Self-checking bench for linear_layer_sched: table of requantization vectors,
// a bench-side dot-product engine model and hand sequences for abort/reset/wrap.
module tb_linear_layer_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [9:0]  num_rows;
    logic [4:0]  out_shift;
    logic        busy;
    logic        done;
    logic [9:0]  row_idx;
    logic        dp_start;
    logic [9:0]  dp_base_addr;
    logic [31:0] dp_result;
    logic        dp_done;
    logic        out_wr_en;
    logic [9:0]  out_wr_addr;
    logic [15:0] out_wr_data;
    logic [2:0]  dbg_state;

    int checks;
    int errors;
    int n_start;
    int n_wr;
    int n_done;

    logic [15:0] exp_q[$];
    logic [31:0] stim_res[$];
    logic [15:0] stim_exp[$];

    typedef struct {
        logic [31:0] res;
        logic [4:0]  sh;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    linear_layer_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .num_rows     (num_rows),
        .out_shift    (out_shift),
        .busy         (busy),
        .done         (done),
        .row_idx      (row_idx),
        .dp_start     (dp_start),
        .dp_base_addr (dp_base_addr),
        .dp_result    (dp_result),
        .dp_done      (dp_done),
        .out_wr_en    (out_wr_en),
        .out_wr_addr  (out_wr_addr),
        .out_wr_data  (out_wr_data),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dp_start)  n_start++;
            if (out_wr_en) n_wr++;
            if (done)      n_done++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_q(input logic [31:0] r, input logic [4:0] s);
        longint v;
        v = longint'($signed(r));
        v = v >>> s;
        if (v > 64'sd32767)  return 16'h7FFF;
        if (v < -64'sd32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Runs a full layer; row results/expectations are taken from stim_res/stim_exp.
    task automatic run_layer(input int rows, input logic [4:0] sh, input int lat, input bit inject);
        logic [9:0] exp_base;
        int         to;
        int         done0;
        exp_base  = '0;
        done0     = n_done;
        num_rows  = 10'(rows);
        out_shift = sh;
        start     = 1'b1;
        step();
        start     = 1'b0;
        num_rows  = 10'($urandom);
        out_shift = 5'($urandom);
        for (int r = 0; r < rows; r++) begin
            to = 0;
            while (!dp_start && to < 20) begin
                step();
                to++;
            end
            check("dp_start_seen", {31'd0, dp_start}, 32'd1);
            if (!dp_start) return;
            check("busy_issue", {31'd0, busy}, 32'd1);
            check("dp_base_addr", {22'd0, dp_base_addr}, {22'd0, exp_base});
            check("row_idx", {22'd0, row_idx}, 32'(r));
            for (int j = 0; j < lat; j++) begin
                step();
                start = (inject && j == 0) ? 1'b1 : 1'b0;
            end
            start     = 1'b0;
            dp_done   = 1'b1;
            dp_result = stim_res.pop_front();
            exp_q.push_back(stim_exp.pop_front());
            step();
            dp_done   = 1'b0;
            dp_result = $urandom;
            check("wr_en", {31'd0, out_wr_en}, 32'd1);
            check("wr_addr", {22'd0, out_wr_addr}, 32'(r) & 32'h3FF);
            check("wr_data", {16'd0, out_wr_data}, {16'd0, exp_q.pop_front()});
            exp_base = exp_base + 10'd8;
        end
        step();
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd1);
        step();
        check("done_clear", {31'd0, done}, 32'd0);
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("done_count", 32'(n_done - done0), 32'd1);
    endtask

    initial begin
        int s0;
        int w0;
        int d0;
        logic [4:0] sh;
        logic [31:0] r;

        vecs[0]  = '{32'd100,        5'd0,  16'd100};
        vecs[1]  = '{32'hFFFFFF38,   5'd0,  16'hFF38};
        vecs[2]  = '{32'd300,        5'd0,  16'd300};
        vecs[3]  = '{32'h0001_2345,  5'd4,  16'h1234};
        vecs[4]  = '{32'hFFFF_FFEF,  5'd4,  16'hFFFE};
        vecs[5]  = '{32'h7FFF_FFFF,  5'd4,  16'h7FFF};
        vecs[6]  = '{32'h8000_0000,  5'd4,  16'h8000};
        vecs[7]  = '{32'h0000_8000,  5'd0,  16'h7FFF};
        vecs[8]  = '{32'hFFFF_7FFF,  5'd0,  16'h8000};
        vecs[9]  = '{32'h8000_0000,  5'd31, 16'hFFFF};
        vecs[10] = '{32'h4000_0000,  5'd31, 16'h0000};

        checks = 0; errors = 0; n_start = 0; n_wr = 0; n_done = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_rows = '0; out_shift = '0;
        dp_result = '0; dp_done = 1'b0;
        repeat (3) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dp_start", {31'd0, dp_start}, 32'd0);
        check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("rst_row_idx", {22'd0, row_idx}, 32'd0);
        check("rst_wr_data", {16'd0, out_wr_data}, 32'd0);
        rst_n = 1'b1;
        step();

        // num_rows = 0: done the cycle after start, nothing issued or written
        s0 = n_start; w0 = n_wr;
        num_rows = '0; start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_dp_start", {31'd0, dp_start}, 32'd0);
        step();
        check("zero_busy_fall", {31'd0, busy}, 32'd0);
        check("zero_no_start", 32'(n_start - s0), 32'd0);
        check("zero_no_write", 32'(n_wr - w0), 32'd0);

        // abort and start together in IDLE: abort wins
        abort = 1'b1; start = 1'b1; num_rows = 10'd2;
        step();
        abort = 1'b0; start = 1'b0;
        check("idle_abort_start", {31'd0, busy}, 32'd0);

        // 3-row layer, shift 0, latency 5, with a start pulse injected mid-layer
        w0 = n_wr;
        for (int i = 0; i < 3; i++) begin
            stim_res.push_back(vecs[i].res);
            stim_exp.push_back(vecs[i].exp);
        end
        run_layer(3, 5'd0, 5, 1'b1);
        check("three_row_writes", 32'(n_wr - w0), 32'd3);

        // requantization table, one single-row layer per vector
        for (int i = 0; i < 11; i++) begin
            stim_res.push_back(vecs[i].res);
            stim_exp.push_back(vecs[i].exp);
            run_layer(1, vecs[i].sh, $urandom_range(1, 4), 1'b0);
        end

        // abort coincident with dp_done on row 1
        num_rows = 10'd3; out_shift = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        w0 = n_wr; d0 = n_done;
        step();
        dp_done = 1'b1; dp_result = 32'd5;
        step();
        dp_done = 1'b0;
        check("abort_row0_wr", {31'd0, out_wr_en}, 32'd1);
        check("abort_row0_data", {16'd0, out_wr_data}, 32'd5);
        step();
        check("abort_row1_issue", {31'd0, dp_start}, 32'd1);
        check("abort_row1_base", {22'd0, dp_base_addr}, 32'd8);
        step();
        dp_done = 1'b1; abort = 1'b1; dp_result = 32'd77;
        step();
        dp_done = 1'b0; abort = 1'b0;
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_row_hold", {22'd0, row_idx}, 32'd1);
        check("abort_base_hold", {22'd0, dp_base_addr}, 32'd8);
        repeat (4) step();
        check("abort_writes", 32'(n_wr - w0), 32'd1);
        check("abort_no_done", 32'(n_done - d0), 32'd0);

        // dp_done in IDLE leaves the captured result alone
        dp_done = 1'b1; dp_result = 32'h7FFF_FFFF;
        step();
        dp_done = 1'b0;
        check("idle_dp_done_busy", {31'd0, busy}, 32'd0);
        check("idle_dp_done_data", {16'd0, out_wr_data}, 32'd5);

        // asynchronous reset while waiting on the engine
        num_rows = 10'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_dp_start", {31'd0, dp_start}, 32'd0);
        check("mid_rst_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_base", {22'd0, dp_base_addr}, 32'd0);
        check("mid_rst_wr_data", {16'd0, out_wr_data}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        stim_res.push_back(vecs[3].res);
        stim_exp.push_back(vecs[3].exp);
        run_layer(1, vecs[3].sh, 2, 1'b0);

        // 129 rows: base address wraps to 0 on row 128
        sh = 5'($urandom_range(0, 31));
        for (int i = 0; i < 129; i++) begin
            r = $urandom;
            stim_res.push_back(r);
            stim_exp.push_back(ref_q(r, sh));
        end
        run_layer(129, sh, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
